// File: rtl/inst_fetch_unit.sv
// Instruction fetch and PC sequencer for the single-cycle MIPS core.
// Fetches one word per instruction over req/ack and holds it until execute commits it.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Resetn,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemAck,
   input  logic [31:0] IMemData,
   output logic [31:0] Inst,
   output logic        InstValid,
   input  logic        InstDone,
   input  logic        Stall,
   input  logic        Jump,
   input  logic        Branch,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] RetireCnt
);

   localparam logic [31:0] ResetPcAligned = RESET_PC & ~32'h3;

   typedef enum logic [1:0] {StIdle, StFetch, StHold} state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] inst_q, inst_d;
   logic        inst_valid_q, inst_valid_d;
   logic        imem_req_q, imem_req_d;
   logic [31:0] retire_cnt_q, retire_cnt_d;

   logic [31:0] pc_plus4;
   logic [31:0] branch_off;
   logic [31:0] next_pc;

   assign pc_plus4   = pc_q + 32'd4;
   assign branch_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

   // Jump has priority over Branch when both are asserted.
   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
      end else if (Branch) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      inst_valid_d = inst_valid_q;
      imem_req_d   = imem_req_q;
      retire_cnt_d = retire_cnt_q;
      case (state_q)
         StIdle: begin
            state_d    = StFetch;
            imem_req_d = 1'b1;
         end
         StFetch: begin
            if (IMemAck) begin
               inst_d       = IMemData;
               inst_valid_d = 1'b1;
               imem_req_d   = 1'b0;
               state_d      = StHold;
            end
         end
         StHold: begin
            if (InstDone && !Stall) begin
               pc_d         = {next_pc[31:2], 2'b00};
               retire_cnt_d = retire_cnt_q + 32'd1;
               inst_valid_d = 1'b0;
               imem_req_d   = 1'b1;
               state_d      = StFetch;
            end
         end
         default: begin
            state_d      = StIdle;
            inst_valid_d = 1'b0;
            imem_req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Resetn) begin
      if (!Resetn) begin
         state_q      <= StIdle;
         pc_q         <= ResetPcAligned;
         inst_q       <= 32'h0;
         inst_valid_q <= 1'b0;
         imem_req_q   <= 1'b0;
         retire_cnt_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         inst_valid_q <= inst_valid_d;
         imem_req_q   <= imem_req_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   assign IMemReq   = imem_req_q;
   assign IMemAddr  = pc_q;
   assign Inst      = inst_q;
   assign InstValid = inst_valid_q;
   assign PC        = pc_q;
   assign PCPlus4   = pc_plus4;
   assign RetireCnt = retire_cnt_q;

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch and PC sequencer for the single-cycle MIPS core.
- Consumes the control unit's Jump/Branch decisions to compute the next PC.
- Fetches instruction words from instruction memory over a req/ack handshake and presents one instruction at a time to decode/execute.
- Sits between instruction memory and ControlUnit/datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- Clk  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- IMemReq  out  1  fetch request to instruction memory.
- IMemAddr  out  32  fetch address; equals PC.
- IMemAck  in  1  memory returns data this cycle.
- IMemData  in  32  instruction word, valid when IMemAck=1.
- Inst  out  32  current instruction to decode.
- InstValid  out  1  Inst is valid and stable.
- InstDone  in  1  execute stage commits Inst this cycle.
- Stall  in  1  hold current instruction; suppresses commit.
- Jump  in  1  from ControlUnit, J-type taken.
- Branch  in  1  from ControlUnit, branch taken (already qualified by Zero).
- PC  out  32  address of current instruction.
- PCPlus4  out  32  PC+4, combinational, for link/branch datapath.
- RetireCnt  out  32  count of committed instructions.

Behaviour:
- Reset (async, Resetn=0):
  - PC=RESET_PC, state=IDLE, IMemReq=0, InstValid=0, Inst=0, RetireCnt=0.
  - Takes effect immediately, including mid-fetch: an outstanding request is dropped and a late IMemAck is ignored.
- States: IDLE, FETCH, HOLD.
- IDLE:
  - Exactly one cycle after reset release.
  - Next edge: state=FETCH, IMemReq=1.
- FETCH:
  - IMemReq=1; IMemAddr=PC, held stable until ack.
  - On edge with IMemAck=1: Inst<=IMemData, InstValid<=1, IMemReq<=0, state=HOLD.
  - Stall and InstDone are ignored in FETCH.
- HOLD:
  - InstValid=1; Inst and PC stable.
  - Commit on an edge with InstDone=1 and Stall=0:
    - PC<=next PC.
    - RetireCnt<=RetireCnt+1, wrapping at 2^32.
    - InstValid<=0, IMemReq<=1, state=FETCH.
  - InstDone=1 with Stall=1: no commit; hold everything.
- Next-PC computation (Jump/Branch are sampled only on the commit edge), in priority order:
  - Jump=1: {PCPlus4[31:28], Inst[25:0], 2'b00}.
  - else Branch=1: PCPlus4 + ({{14{Inst[15]}}, Inst[15:0], 2'b00}), 32-bit modulo add.
  - else: PCPlus4.
- Priority and width rules:
  - Jump and Branch both 1: Jump wins.
  - PCPlus4 = PC+4 modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
  - PC[1:0] is forced to 00 on every load.
- IMemAck outside FETCH is ignored; Inst is not updated.
- IMemAck combinational in the first FETCH cycle gives InstValid the next cycle.
- Minimum throughput: 2 cycles per instruction (FETCH with ack, then HOLD with commit).
- Outputs IMemReq, InstValid, Inst, PC, and RetireCnt are registered; PCPlus4 and IMemAddr are combinational from PC.

Test Plan:
- Reset, then release with IMemAck tied 1 and InstDone tied 1, memory returning 0x2008_0005 (addi): IMemReq rises 1 cycle after release at IMemAddr=0x0. Required sequence: InstValid alternates, PC steps 0x0, 0x4, 0x8, and RetireCnt=3 after three commits.
- Memory with 3-cycle ack latency: IMemAddr stays at 0x4 and IMemReq stays 1 for all 3 cycles. InstValid rises the cycle after ack, with Inst equal to the acked word.
- PC=0x0C, Inst=0x0800_0040, Jump=1 at commit: next IMemAddr=0x0000_0100. Repeat with Jump=1 and Branch=1 simultaneously: still 0x100.
- PC=0x10, Inst=0x1000_FFFE (beq), Branch=1: next PC=0x0C. Same instruction with Branch=0: next PC=0x14.
- HOLD with InstDone=1 and Stall=1 for 4 cycles: PC, Inst, and RetireCnt are unchanged and InstValid stays 1. Dropping Stall commits on the next edge.
- Two cases around the fetch state machine:
  - Resetn pulsed low mid-FETCH at PC=0x20: IMemReq=0 and PC=RESET_PC immediately, and a late IMemAck does not raise InstValid.
  - RESET_PC=0xFFFF_FFFC with a sequential commit: next PC=0x0000_0000.
